dcache_controller: RTL and testbench

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

---
 rtl/dcache_controller.sv | 189 ++++++++++++++++++
 tb/tb_dcache_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
`timescale 1ns/1ps
// dcache_controller
//   Write-back, write-allocate data cache controller. The tag/data SRAM
//   (with hit detection and victim selection) and main memory are external;
//   this block sequences hits, victim write-back and line refill.
//
//   Ports
//     clk_i, rst_i              clock, synchronous active-high reset
//     cpu_addr_i/cpu_data_i     CPU byte address / store data
//     cpu_MemRead_i/MemWrite_i  load / store request (both high = store)
//     cpu_data_o, cpu_stall_o   load data, pipeline stall
//     sram_*                    set index, tag {valid,dirty,tag}, line, strobes
//     mem_*                     line address, write-back line, strobes, ack
//     hit_cnt_o/miss_cnt_o      performance counters
//
//   Optional feature: define DCACHE_PERF_CNT_EN to build saturating hit/miss
//   counters; otherwise both counter outputs are tied to zero.
//
//   state      | meaning
//   S_IDLE     | serve hits, detect misses
//   S_MISS     | inspect victim line, capture it if dirty
//   S_WRITEBACK| write dirty victim to memory
//   S_READMISS | fetch requested line from memory, fill SRAM on ack
//   S_READMISSOK| one settle cycle before the request is re-evaluated
module dcache_controller (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic [3:0]   sram_addr_o,
    output logic [24:0]  sram_tag_o,
    output logic [255:0] sram_data_o,
    output logic         sram_enable_o,
    output logic         sram_write_o,
    input  logic [24:0]  sram_tag_i,
    input  logic [255:0] sram_data_i,
    input  logic         sram_hit_i,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [31:0]  hit_cnt_o,
    output logic [31:0]  miss_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_WRITEBACK,
        S_READMISS,
        S_READMISSOK
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_req;
    logic [2:0]     w_word;
    logic [3:0]     w_index;
    logic [22:0]    w_tag;
    logic           w_victim_dirty;
    logic [255:0]   w_merged;
    logic [22:0]    r_victim_tag;
    logic [255:0]   r_victim_data;

    assign w_req          = cpu_MemRead_i | cpu_MemWrite_i;
    assign w_word         = cpu_addr_i[4:2];
    assign w_index        = cpu_addr_i[8:5];
    assign w_tag          = cpu_addr_i[31:9];
    assign w_victim_dirty = sram_tag_i[24] & sram_tag_i[23];

    assign sram_enable_o  = w_req;
    assign sram_addr_o    = w_index;
    assign cpu_stall_o    = (r_state != S_IDLE) | (w_req & ~sram_hit_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_victim_tag  <= '0;
            r_victim_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_MISS) begin
                r_victim_tag  <= sram_tag_i[22:0];
                r_victim_data <= sram_data_i;
            end
        end
    end

    always_comb begin
        w_merged                 = sram_data_i;
        w_merged[32*w_word +: 32] = cpu_data_i;
    end

    always_comb begin
        w_state_nxt  = r_state;
        cpu_data_o   = '0;
        sram_write_o = 1'b0;
        sram_tag_o   = '0;
        sram_data_o  = sram_data_i;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = {w_tag, w_index, 5'b0};
        mem_data_o   = r_victim_data;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (sram_hit_i) begin
                        if (cpu_MemWrite_i) begin
                            sram_write_o = 1'b1;
                            sram_data_o  = w_merged;
                            sram_tag_o   = {1'b1, 1'b1, w_tag};
                        end else begin
                            cpu_data_o = sram_data_i[32*w_word +: 32];
                        end
                    end else begin
                        w_state_nxt = S_MISS;
                    end
                end
            end
            S_MISS: begin
                w_state_nxt = w_victim_dirty ? S_WRITEBACK : S_READMISS;
            end
            S_WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {r_victim_tag, w_index, 5'b0};
                if (mem_ack_i) w_state_nxt = S_READMISS;
            end
            S_READMISS: begin
                mem_enable_o = 1'b1;
                if (mem_ack_i) begin
                    sram_write_o = 1'b1;
                    sram_data_o  = mem_data_i;
                    sram_tag_o   = {1'b1, 1'b0, w_tag};
                    w_state_nxt  = S_READMISSOK;
                end
            end
            S_READMISSOK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Strobes are forced quiet during reset so nothing escapes in the
        // cycle the reset is applied.
        if (rst_i) begin
            cpu_data_o   = '0;
            sram_write_o = 1'b0;
            mem_enable_o = 1'b0;
            mem_write_o  = 1'b0;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic        w_hit_evt;
    logic        w_miss_evt;

    assign w_hit_evt  = (r_state == S_IDLE) & w_req & sram_hit_i;
    assign w_miss_evt = (r_state == S_IDLE) & w_req & ~sram_hit_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_evt && (r_hit_cnt != 32'hFFFF_FFFF))
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (w_miss_evt && (r_miss_cnt != 32'hFFFF_FFFF))
                r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    assign hit_cnt_o  = 32'd0;
    assign miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
`timescale 1ns/1ps
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  cpu_addr_i = '0;
    logic [31:0]  cpu_data_i = '0;
    logic         cpu_MemRead_i = 1'b0;
    logic         cpu_MemWrite_i = 1'b0;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    always #5 clk_i = ~clk_i;

    dcache_controller u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- backing data ----------------
    function automatic logic [31:0] init_word(input logic [31:0] waddr);
        return (waddr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    logic [255:0] backing [int unsigned];
    logic [31:0]  gold    [int unsigned];

    function automatic logic [255:0] read_line(input logic [31:0] byte_addr);
        logic [255:0] l;
        int unsigned  ln;
        ln = byte_addr >> 5;
        if (backing.exists(ln)) return backing[ln];
        for (int i = 0; i < 8; i++) l[32*i +: 32] = init_word((ln << 3) + i);
        return l;
    endfunction

    function automatic logic [31:0] gold_rd(input logic [31:0] byte_addr);
        int unsigned wa;
        wa = byte_addr >> 2;
        return gold.exists(wa) ? gold[wa] : init_word(wa);
    endfunction

    // ---------------- SRAM model (direct mapped, 16 sets) ----------------
    logic [24:0]  sram_tag_arr [16];
    logic [255:0] sram_dat_arr [16];
    int           sram_wr_cnt = 0;
    logic         tb_clear = 1'b1;

    assign sram_tag_i  = sram_tag_arr[sram_addr_o];
    assign sram_data_i = sram_dat_arr[sram_addr_o];
    assign sram_hit_i  = sram_enable_o && sram_tag_i[24] && (sram_tag_i[22:0] == cpu_addr_i[31:9]);

    always @(posedge clk_i) begin
        if (tb_clear) begin
            for (int i = 0; i < 16; i++) begin
                sram_tag_arr[i] <= '0;
                sram_dat_arr[i] <= '0;
            end
        end else if (sram_write_o) begin
            sram_tag_arr[sram_addr_o] <= sram_tag_o;
            sram_dat_arr[sram_addr_o] <= sram_data_o;
            sram_wr_cnt <= sram_wr_cnt + 1;
        end
    end

    // ---------------- memory model: ack in the Nth enabled cycle ----------------
    int          lat_q[$];
    int          mem_cnt = 0;
    int          cur_lat = 2;
    int          wb_cnt = 0;
    int          ack_seen = 0;
    logic [31:0] last_wb_addr = '0;
    logic        force_ack = 1'b0;

    always @(negedge clk_i) begin
        if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            mem_cnt   = 0;
        end
        if (force_ack) begin
            mem_ack_i = 1'b1;
            ack_seen++;
        end else if (mem_enable_o) begin
            if (mem_cnt == 0) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 2;
            mem_cnt++;
            if (mem_cnt >= cur_lat) begin
                mem_ack_i = 1'b1;
                if (mem_write_o) begin
                    backing[mem_addr_o >> 5] = mem_data_o;
                    last_wb_addr = mem_addr_o;
                    wb_cnt++;
                end else begin
                    mem_data_i = read_line(mem_addr_o);
                end
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // ---------------- reference model of cache occupancy ----------------
    bit          m_valid [16];
    bit          m_dirty [16];
    logic [22:0] m_tag   [16];
    int          exp_hits = 0;
    int          exp_miss = 0;

    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input int lwb, input int lrd);
        logic [22:0] t;
        logic [3:0]  idx;
        logic [2:0]  w;
        bit          e_hit, e_wb;
        int          e_stall, stalls, wb0;
        logic [31:0] e_wb_addr;
        t   = addr[31:9];
        idx = addr[8:5];
        w   = addr[4:2];
        e_hit     = m_valid[idx] && (m_tag[idx] == t);
        e_wb      = !e_hit && m_valid[idx] && m_dirty[idx];
        e_stall   = e_hit ? 0 : (3 + lrd + (e_wb ? lwb : 0));
        e_wb_addr = {m_tag[idx], idx, 5'b0};
        wb0       = wb_cnt;
        lat_q.delete();
        if (!e_hit) begin
            if (e_wb) lat_q.push_back(lwb);
            lat_q.push_back(lrd);
        end
        @(negedge clk_i);
        cpu_addr_i     = addr;
        cpu_data_i     = data;
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        #1;
        stalls = 0;
        while (cpu_stall_o && stalls < 300) begin
            stalls++;
            @(negedge clk_i);
            #1;
        end
        chk("stall_release", {31'd0, cpu_stall_o}, 32'd0);
        chk("stall_cycles", stalls, e_stall);
        if (!e_hit) begin
            chk("writebacks", wb_cnt - wb0, {31'd0, e_wb});
            if (e_wb) chk("wb_addr", last_wb_addr, e_wb_addr);
            chk("refill_tag", {7'd0, sram_tag_arr[idx]}, {7'd0, 1'b1, 1'b0, t});
        end
        if (wr) begin
            chk("store_wr", {31'd0, sram_write_o}, 32'd1);
            chk("store_tag", {7'd0, sram_tag_o}, {7'd0, 1'b1, 1'b1, t});
            chk("store_word", sram_data_o[32*w +: 32], data);
            chk("store_keep", sram_data_o[32*(w+3'd1) +: 32], gold_rd({addr[31:5], w + 3'd1, 2'b00}));
            gold[addr >> 2] = data;
        end else begin
            chk("load_data", cpu_data_o, gold_rd(addr));
            chk("load_nowr", {31'd0, sram_write_o}, 32'd0);
        end
        @(posedge clk_i);
        exp_hits++;
        if (!e_hit) exp_miss++;
        m_dirty[idx] = (e_hit ? m_dirty[idx] : 1'b0) | wr;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = t;
        @(negedge clk_i);
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    task automatic chk_counters(input string tag);
`ifdef DCACHE_PERF_CNT_EN
        chk({tag, "_hits"}, hit_cnt_o, exp_hits);
        chk({tag, "_miss"}, miss_cnt_o, exp_miss);
`else
        chk({tag, "_hits"}, hit_cnt_o, 32'd0);
        chk({tag, "_miss"}, miss_cnt_o, 32'd0);
`endif
    endtask

    initial begin
        int en_seen, wr0, ack0;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0;
        end
        repeat (3) @(posedge clk_i);
        tb_clear = 1'b0;
        @(negedge clk_i);
        chk("rst_mem_en", {31'd0, mem_enable_o}, 32'd0);
        chk("rst_sram_wr", {31'd0, sram_write_o}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i); #1;
        chk("idle_stall", {31'd0, cpu_stall_o}, 32'd0);
        chk("idle_mem_wr", {31'd0, mem_write_o}, 32'd0);
        chk("idle_cpu_data", cpu_data_o, 32'd0);
        chk_counters("rst_cnt");

        // cold load, long memory latency, clean victim
        access(1, 0, 32'h0000_0044, 32'h0, 1, 10);
        // store hit into the refilled line
        access(0, 1, 32'h0000_0048, 32'hDEAD_BEEF, 1, 1);
        access(1, 0, 32'h0000_0048, 32'h0, 1, 1);
        // evict the dirty tag-0 line, then dirty tag 5 and evict it back
        access(1, 0, 32'h0000_0A40, 32'h0, 3, 4);
        access(0, 1, 32'h0000_0A44, 32'h1111_2222, 1, 1);
        access(1, 0, 32'h0000_0048, 32'h0, 2, 3);
        access(1, 0, 32'h0000_0A44, 32'h0, 1, 2);
        // both request lines high behaves as a store
        access(1, 1, 32'h0000_0A48, 32'hCAFE_F00D, 1, 1);
        access(1, 0, 32'h0000_0A48, 32'h0, 1, 1);
        chk_counters("dir_cnt");

        // reset during the third READMISS cycle abandons the refill
        lat_q.delete();
        lat_q.push_back(10);
        @(negedge clk_i);
        cpu_addr_i    = 32'h0000_00E4;
        cpu_MemRead_i = 1'b1;
        en_seen = 0;
        for (int c = 0; c < 50 && en_seen < 3; c++) begin
            @(negedge clk_i); #1;
            if (mem_enable_o) en_seen++;
        end
        chk("rm_entered", en_seen, 3);
        wr0 = sram_wr_cnt;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        cpu_MemRead_i = 1'b0;
        #1;
        chk("abort_mem_en", {31'd0, mem_enable_o}, 32'd0);
        chk("abort_stall", {31'd0, cpu_stall_o}, 32'd0);
        exp_hits = 0;
        exp_miss = 0;
        chk_counters("abort_cnt");
        ack0 = ack_seen;
        force_ack = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        force_ack = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("late_ack_seen", {31'd0, ack_seen > ack0}, 32'd1);
        chk("late_ack_nowr", sram_wr_cnt - wr0, 32'd0);
        access(1, 0, 32'h0000_00E4, 32'h0, 1, 2);

        // randomized traffic over a small tag range to force conflicts
        for (int n = 0; n < 150; n++) begin
            int op;
            a = {21'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), 2'b00};
            op = $urandom_range(0, 2);
            access(op != 1, op != 0, a, $urandom,
                   $urandom_range(1, 4), $urandom_range(1, 4));
        end
        chk_counters("end_cnt");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
